// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared exception codes, PC vectors and exception merge helper
package pipe_stage_reg_pkg;

    typedef logic [4:0] exc_code_t;

    localparam exc_code_t EXC_INT  = 5'd0;
    localparam exc_code_t EXC_ADEL = 5'd4;
    localparam exc_code_t EXC_ADES = 5'd5;
    localparam exc_code_t EXC_RI   = 5'd10;
    localparam exc_code_t EXC_OV   = 5'd12;

    localparam logic [31:0] PC_RST_DEF     = 32'h0000_3000;
    localparam logic [31:0] PC_HANDLER_DEF = 32'h0000_4180;

    // The oldest exception in program order wins; bubbles never carry one.
    function automatic exc_code_t merge_exc(input logic valid, input exc_code_t older,
                                            input exc_code_t newer);
        if (!valid)
            return EXC_INT;
        return (older != EXC_INT) ? older : newer;
    endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// rtl/pipe_field_reg.sv - W-bit payload register with clear/load/hold
module pipe_field_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q = '0;

    always_ff @(posedge clk) begin
        if (reset || i_clear)
            r_q <= '0;
        else if (i_load)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with stall, flush bubble and exception redirect
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          W          = 32,
    parameter int          NCH        = 7,
    parameter int          CNT_W      = 8,
    parameter logic [W-1:0] PC_RST     = PC_RST_DEF,
    parameter logic [W-1:0] PC_HANDLER = PC_HANDLER_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [W-1:0]     in_ir,
    input  logic [W-1:0]     in_pc,
    input  logic             in_bd,
    input  logic [4:0]       in_exc,
    input  logic [4:0]       new_exc,
    input  logic [NCH*W-1:0] in_data,
    output logic             out_valid,
    output logic [W-1:0]     out_ir,
    output logic [W-1:0]     out_pc,
    output logic             out_bd,
    output logic [4:0]       out_exc,
    output logic [NCH*W-1:0] out_data,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_valid = 1'b0;
    logic [W-1:0]     r_ir    = '0;
    logic [W-1:0]     r_pc    = PC_RST;
    logic             r_bd    = 1'b0;
    exc_code_t        r_exc   = EXC_INT;
    logic [CNT_W-1:0] r_cnt   = '0;

    logic w_clear;
    logic w_load;

    assign w_clear = req | flush;
    assign w_load  = ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ir    <= '0;
            r_pc    <= PC_RST;
            r_bd    <= 1'b0;
            r_exc   <= EXC_INT;
            r_cnt   <= '0;
        end else if (req) begin
            r_valid <= 1'b0;
            r_ir    <= '0;
            r_pc    <= PC_HANDLER;
            r_bd    <= 1'b0;
            r_exc   <= EXC_INT;
            r_cnt   <= '0;
        end else if (flush) begin
            // Bubble keeps the stalled instruction's PC/BD so an interrupt taken here is precise.
            r_valid <= 1'b0;
            r_ir    <= '0;
            r_pc    <= in_pc;
            r_bd    <= in_bd;
            r_exc   <= EXC_INT;
            r_cnt   <= '0;
        end else if (stall) begin
            if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_valid <= in_valid;
            r_ir    <= in_ir;
            r_pc    <= in_pc;
            r_bd    <= in_bd;
            r_exc   <= merge_exc(in_valid, in_exc, new_exc);
            r_cnt   <= '0;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        pipe_field_reg #(.W(W)) u_field (
            .clk     (clk),
            .reset   (reset),
            .i_clear (w_clear),
            .i_load  (w_load),
            .i_d     (in_data[k*W +: W]),
            .o_q     (out_data[k*W +: W])
        );
    end

    assign out_valid = r_valid;
    assign out_ir    = r_ir;
    assign out_pc    = r_pc;
    assign out_bd    = r_bd;
    assign out_exc   = r_exc;
    assign hold_cnt  = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int W     = 32;
    localparam int NCH   = 7;
    localparam int CNT_W = 8;
    localparam int DW    = NCH * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0, req = 1'b0, flush = 1'b0, stall = 1'b0;
    logic          in_valid = 1'b0, in_bd = 1'b0;
    logic [W-1:0]  in_ir = '0, in_pc = '0;
    logic [4:0]    in_exc = '0, new_exc = '0;
    logic [DW-1:0] in_data = '0;

    logic             out_valid, out_bd;
    logic [W-1:0]     out_ir, out_pc;
    logic [4:0]       out_exc;
    logic [DW-1:0]    out_data;
    logic [CNT_W-1:0] hold_cnt;

    logic             s_valid, s_bd;
    logic [W-1:0]     s_ir, s_pc;
    logic [4:0]       s_exc;
    logic [DW-1:0]    s_data;
    logic [1:0]       s_cnt;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ir(in_ir), .in_pc(in_pc), .in_bd(in_bd),
        .in_exc(in_exc), .new_exc(new_exc), .in_data(in_data),
        .out_valid(out_valid), .out_ir(out_ir), .out_pc(out_pc), .out_bd(out_bd),
        .out_exc(out_exc), .out_data(out_data), .hold_cnt(hold_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ir(in_ir), .in_pc(in_pc), .in_bd(in_bd),
        .in_exc(in_exc), .new_exc(new_exc), .in_data(in_data),
        .out_valid(s_valid), .out_ir(s_ir), .out_pc(s_pc), .out_bd(s_bd),
        .out_exc(s_exc), .out_data(s_data), .hold_cnt(s_cnt)
    );

    // Reference stage contents, advanced once per clock edge from the current inputs.
    logic          m_valid = 1'b0, m_bd = 1'b0;
    logic [W-1:0]  m_ir = '0, m_pc = 32'h0000_3000;
    logic [4:0]    m_exc = '0;
    logic [DW-1:0] m_data = '0;
    int            m_cnt = 0, m_cnt2 = 0;

    int n_pass = 0, n_total = 0;

    task automatic model_edge();
        if (reset) begin
            m_valid = 0; m_ir = 0; m_pc = 32'h0000_3000; m_bd = 0; m_exc = 0; m_data = 0;
            m_cnt = 0; m_cnt2 = 0;
        end else if (req) begin
            m_valid = 0; m_ir = 0; m_pc = 32'h0000_4180; m_bd = 0; m_exc = 0; m_data = 0;
            m_cnt = 0; m_cnt2 = 0;
        end else if (flush) begin
            m_valid = 0; m_ir = 0; m_pc = in_pc; m_bd = in_bd; m_exc = 0; m_data = 0;
            m_cnt = 0; m_cnt2 = 0;
        end else if (stall) begin
            m_cnt  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
        end else begin
            m_valid = in_valid; m_ir = in_ir; m_pc = in_pc; m_bd = in_bd; m_data = in_data;
            if (!in_valid)      m_exc = 0;
            else if (in_exc != 0) m_exc = in_exc;
            else                m_exc = new_exc;
            m_cnt = 0; m_cnt2 = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; req = 0; flush = 0; stall = 0; in_valid = 0; in_bd = 0;
        in_ir = 0; in_pc = 0; in_exc = 0; new_exc = 0; in_data = 0;
    endtask

    task automatic rand_inputs();
        in_valid = 1'($urandom); in_bd = 1'($urandom);
        in_ir = $urandom; in_pc = $urandom;
        in_exc  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
        new_exc = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
        for (int k = 0; k < NCH; k++) in_data[k*W +: W] = $urandom;
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if (out_pc !== 32'h0000_3000 || out_valid !== 1'b0 || hold_cnt !== 8'd0)
            $display("FAIL init_values: pc=%h valid=%b cnt=%0d required pc=00003000 valid=0 cnt=0",
                     out_pc, out_valid, hold_cnt);
        else n_pass++;
        clear_inputs();
        reset = 1; in_valid = 1; in_ir = 32'hFFFF_FFFF; in_data = '1;
        tick();
        clear_inputs();
        n_total++;
        if ({out_valid, out_ir, out_bd, out_exc, out_data, hold_cnt} !== '0 || out_pc !== 32'h0000_3000)
            $display("FAIL reset_state: valid=%b ir=%h pc=%h bd=%b exc=%0d cnt=%0d required zeros, pc=00003000",
                     out_valid, out_ir, out_pc, out_bd, out_exc, hold_cnt);
        else n_pass++;
    endtask

    task automatic test_load();
        in_valid = 1; in_ir = 32'h3C01_1234; in_pc = 32'h0000_3008;
        in_data = '0; in_data[31:0] = 32'hDEAD_BEEF;
        tick();
        n_total++;
        if (out_ir !== 32'h3C01_1234 || out_pc !== 32'h0000_3008 || out_valid !== 1'b1)
            $display("FAIL load_ctrl: ir=%h pc=%h valid=%b required 3c011234 00003008 1", out_ir, out_pc, out_valid);
        else n_pass++;
        n_total++;
        if (out_data[31:0] !== 32'hDEAD_BEEF || out_data[DW-1:32] !== '0)
            $display("FAIL load_data: ch0=%h required deadbeef", out_data[31:0]);
        else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 1; i <= 3; i++) begin
            stall = 1; in_ir = $urandom; in_pc = $urandom; in_data = {NCH{$urandom}};
            tick();
            n_total++;
            if (out_ir !== 32'h3C01_1234 || out_pc !== 32'h0000_3008 ||
                out_data[31:0] !== 32'hDEAD_BEEF || out_valid !== 1'b1 || hold_cnt !== CNT_W'(i))
                $display("FAIL stall_hold_%0d: ir=%h pc=%h ch0=%h cnt=%0d required 3c011234 00003008 deadbeef %0d",
                         i, out_ir, out_pc, out_data[31:0], hold_cnt, i);
            else n_pass++;
        end
        stall = 0; in_ir = 32'h1111_2222; in_pc = 32'h0000_300C; in_data[31:0] = 32'h0BAD_F00D;
        tick();
        n_total++;
        if (out_ir !== 32'h1111_2222 || out_pc !== 32'h0000_300C ||
            out_data[31:0] !== 32'h0BAD_F00D || hold_cnt !== 8'd0)
            $display("FAIL stall_release: ir=%h pc=%h ch0=%h cnt=%0d required 11112222 0000300c 0badf00d 0",
                     out_ir, out_pc, out_data[31:0], hold_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (s_cnt !== exp_seq[i] || hold_cnt !== CNT_W'(i + 1))
                $display("FAIL saturation_%0d: cnt2=%0d cnt8=%0d required %0d %0d",
                         i, s_cnt, hold_cnt, exp_seq[i], i + 1);
            else n_pass++;
        end
        stall = 0;
        tick();
    endtask

    task automatic test_flush_stall();
        flush = 1; stall = 1; in_valid = 1; in_pc = 32'h0000_3010; in_bd = 1;
        in_ir = 32'h2408_0001; in_exc = EXC_RI; in_data = {NCH{32'hA5A5_5A5A}};
        tick();
        n_total++;
        if (out_ir !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_exc !== 5'd0 ||
            out_pc !== 32'h0000_3010 || out_bd !== 1'b1 || hold_cnt !== 8'd0)
            $display("FAIL flush_stall: ir=%h valid=%b data_nz=%b exc=%0d pc=%h bd=%b cnt=%0d required 0 0 0 0 00003010 1 0",
                     out_ir, out_valid, |out_data, out_exc, out_pc, out_bd, hold_cnt);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_exc_merge();
        logic       v_tab [3];
        logic [4:0] i_tab [3];
        logic [4:0] n_tab [3];
        logic [4:0] e_tab [3];
        v_tab = '{1'b1, 1'b1, 1'b0};
        i_tab = '{EXC_ADEL, EXC_INT, EXC_ADEL};
        n_tab = '{EXC_OV, EXC_OV, EXC_OV};
        e_tab = '{5'd4, 5'd12, 5'd0};
        for (int i = 0; i < 3; i++) begin
            in_valid = v_tab[i]; in_exc = i_tab[i]; new_exc = n_tab[i];
            tick();
            n_total++;
            if (out_exc !== e_tab[i])
                $display("FAIL exc_merge_%0d: exc=%0d required %0d", i, out_exc, e_tab[i]);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_req_stall();
        in_valid = 1; in_ir = 32'h8C22_0004; in_pc = 32'h0000_3020; in_bd = 1;
        in_exc = EXC_ADES; in_data = {NCH{32'h1234_5678}};
        tick();
        stall = 1;
        tick();
        req = 1;
        tick();
        n_total++;
        if (out_pc !== 32'h0000_4180 || {out_valid, out_ir, out_bd, out_exc, out_data, hold_cnt} !== '0)
            $display("FAIL req_stall: pc=%h valid=%b ir=%h bd=%b exc=%0d data_nz=%b cnt=%0d required 00004180 and zeros",
                     out_pc, out_valid, out_ir, out_bd, out_exc, |out_data, hold_cnt);
        else n_pass++;
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        n_total++;
        if (out_pc !== 32'h0000_3000)
            $display("FAIL req_then_reset: pc=%h required 00003000", out_pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        in_valid = 1; in_ir = 32'hCAFE_0001; in_pc = 32'h0000_3040;
        tick();
        stall = 1;
        tick(); tick();
        reset = 1;
        tick();
        clear_inputs();
        n_total++;
        if (hold_cnt !== 8'd0 || out_ir !== '0 || out_valid !== 1'b0 || out_pc !== 32'h0000_3000)
            $display("FAIL reset_mid_stall: cnt=%0d ir=%h valid=%b pc=%h required 0 0 0 00003000",
                     hold_cnt, out_ir, out_valid, out_pc);
        else n_pass++;
    endtask

    task automatic test_random();
        int run = 0;
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            reset = ($urandom_range(0, 63) == 0);
            req   = ($urandom_range(0, 15) == 0);
            flush = ($urandom_range(0, 7) == 0);
            if (run > 0) begin stall = 1; run--; end
            else if ($urandom_range(0, 19) == 0) begin stall = 1; run = $urandom_range(3, 8); end
            else stall = ($urandom_range(0, 2) == 0);
            tick();
            n_total++;
            if ({out_valid, out_ir, out_pc, out_bd, out_exc, out_data} !== {m_valid, m_ir, m_pc, m_bd, m_exc, m_data} ||
                hold_cnt !== CNT_W'(m_cnt) || s_cnt !== 2'(m_cnt2))
                $display("FAIL random_%0d: v=%b ir=%h pc=%h bd=%b exc=%0d cnt=%0d/%0d data=%h required v=%b ir=%h pc=%h bd=%b exc=%0d cnt=%0d/%0d data=%h",
                         c, out_valid, out_ir, out_pc, out_bd, out_exc, hold_cnt, s_cnt, out_data,
                         m_valid, m_ir, m_pc, m_bd, m_exc, m_cnt, m_cnt2, m_data);
            else n_pass++;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_saturation();
        test_flush_stall();
        test_exc_merge();
        test_req_stall();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
